// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALUOp encodings and the control
// bundle carried through the ID/EX register.
package rv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [1:0] ALUOP_ADD = 2'b00;
   localparam logic [1:0] ALUOP_BR  = 2'b01;
   localparam logic [1:0] ALUOP_R   = 2'b10;
   localparam logic [1:0] ALUOP_I   = 2'b11;

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       alu_src;
      logic       alu_src_a;
      logic       branch;
      logic       jump;
      logic [1:0] alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_hazard_stage_if.sv
// Signal bundle between fetch/writeback (master) and the decode stage (slave).
interface id_hazard_stage_if;
   logic [31:0] Instruc_IFID;
   logic [31:0] PC_IFID;
   logic        PCSrc_EX;
   logic        RegWrite_WB;
   logic [4:0]  Rd_WB;
   logic [31:0] WriteData_WB;
   logic        PCWrite;
   logic        Write_IFID;
   logic [31:0] PC_IDEX;
   logic [31:0] RD1_IDEX;
   logic [31:0] RD2_IDEX;
   logic [31:0] Imm_IDEX;
   logic [4:0]  Rs1_IDEX;
   logic [4:0]  Rs2_IDEX;
   logic [4:0]  Rd_IDEX;
   logic [2:0]  Funct3_IDEX;
   logic        Funct7b5_IDEX;
   logic        RegWrite_IDEX;
   logic        MemRead_IDEX;
   logic        MemWrite_IDEX;
   logic        MemToReg_IDEX;
   logic        ALUSrc_IDEX;
   logic        ALUSrcA_IDEX;
   logic        Branch_IDEX;
   logic        Jump_IDEX;
   logic [1:0]  ALUOp_IDEX;

   modport master (
      output Instruc_IFID, PC_IFID, PCSrc_EX, RegWrite_WB, Rd_WB, WriteData_WB,
      input  PCWrite, Write_IFID, PC_IDEX, RD1_IDEX, RD2_IDEX, Imm_IDEX,
             Rs1_IDEX, Rs2_IDEX, Rd_IDEX, Funct3_IDEX, Funct7b5_IDEX,
             RegWrite_IDEX, MemRead_IDEX, MemWrite_IDEX, MemToReg_IDEX,
             ALUSrc_IDEX, ALUSrcA_IDEX, Branch_IDEX, Jump_IDEX, ALUOp_IDEX
   );

   modport slave (
      input  Instruc_IFID, PC_IFID, PCSrc_EX, RegWrite_WB, Rd_WB, WriteData_WB,
      output PCWrite, Write_IFID, PC_IDEX, RD1_IDEX, RD2_IDEX, Imm_IDEX,
             Rs1_IDEX, Rs2_IDEX, Rd_IDEX, Funct3_IDEX, Funct7b5_IDEX,
             RegWrite_IDEX, MemRead_IDEX, MemWrite_IDEX, MemToReg_IDEX,
             ALUSrc_IDEX, ALUSrcA_IDEX, Branch_IDEX, Jump_IDEX, ALUOp_IDEX
   );
endinterface

// File: rtl/regfile_2r1w.sv
// 32x32 register file, two async read ports, one write port; x0 is hardwired 0.
// Define IDHZ_WB_BYPASS_EN to return same-cycle write data on a matching read.
module regfile_2r1w (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd
);
   logic [31:0] regs [1:31];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < 32; i++) regs[i] <= '0;
      end else if (we && (wa != 5'd0)) begin
         regs[wa] <= wd;
      end
   end

`ifdef IDHZ_WB_BYPASS_EN
   assign rd1 = (ra1 == 5'd0) ? '0 : (we && (wa == ra1)) ? wd : regs[ra1];
   assign rd2 = (ra2 == 5'd0) ? '0 : (we && (wa == ra2)) ? wd : regs[ra2];
`else
   // Pre-write value is returned; EX forwarding must cover distance 3.
   assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
   assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];
`endif

endmodule

// File: rtl/id_hazard_stage.sv
// RV32I decode stage: decode, immediates, load-use stall and branch squash
// feeding the ID/EX register. WB bypass is selected by IDHZ_WB_BYPASS_EN.
import rv_pkg::*;

module id_hazard_stage (
   input  logic             clk,
   input  logic             rst_n,
   id_hazard_stage_if.slave bus
);
   logic [31:0] instr;
   logic [6:0]  opcode;
   ctrl_t       ctrl_d, ctrl_q;
   logic [31:0] imm_d;
   logic        use_rs1, use_rs2, legal;
   logic [4:0]  rs1_d, rs2_d, rd_d;
   logic [31:0] rd1, rd2;
   logic        load_use, bubble, squash_q;

   logic [31:0] pc_q, rd1_q, rd2_q, imm_q;
   logic [4:0]  rs1_q, rs2_q, rd_q;
   logic [2:0]  funct3_q;
   logic        funct7b5_q;

   assign instr  = bus.Instruc_IFID;
   assign opcode = instr[6:0];

   always_comb begin
      ctrl_d  = CTRL_BUBBLE;
      imm_d   = '0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      legal   = 1'b1;
      case (opcode)
         OP_R: begin
            ctrl_d.reg_write = 1'b1; ctrl_d.alu_op = ALUOP_R;
            use_rs1 = 1'b1; use_rs2 = 1'b1;
         end
         OP_IALU: begin
            ctrl_d.reg_write = 1'b1; ctrl_d.alu_src = 1'b1; ctrl_d.alu_op = ALUOP_I;
            use_rs1 = 1'b1;
            imm_d = {{20{instr[31]}}, instr[31:20]};
         end
         OP_LOAD: begin
            ctrl_d.reg_write = 1'b1; ctrl_d.mem_read = 1'b1;
            ctrl_d.mem_to_reg = 1'b1; ctrl_d.alu_src = 1'b1;
            use_rs1 = 1'b1;
            imm_d = {{20{instr[31]}}, instr[31:20]};
         end
         OP_STORE: begin
            ctrl_d.mem_write = 1'b1; ctrl_d.alu_src = 1'b1;
            use_rs1 = 1'b1; use_rs2 = 1'b1;
            imm_d = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         end
         OP_BRANCH: begin
            ctrl_d.branch = 1'b1; ctrl_d.alu_op = ALUOP_BR;
            use_rs1 = 1'b1; use_rs2 = 1'b1;
            imm_d = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         end
         OP_JAL: begin
            ctrl_d.reg_write = 1'b1; ctrl_d.jump = 1'b1;
            ctrl_d.alu_src = 1'b1; ctrl_d.alu_src_a = 1'b1;
            imm_d = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         end
         OP_JALR: begin
            ctrl_d.reg_write = 1'b1; ctrl_d.jump = 1'b1; ctrl_d.alu_src = 1'b1;
            use_rs1 = 1'b1;
            imm_d = {{20{instr[31]}}, instr[31:20]};
         end
         OP_LUI: begin
            ctrl_d.reg_write = 1'b1; ctrl_d.alu_src = 1'b1;
            imm_d = {instr[31:12], 12'b0};
         end
         OP_AUIPC: begin
            ctrl_d.reg_write = 1'b1; ctrl_d.alu_src = 1'b1; ctrl_d.alu_src_a = 1'b1;
            imm_d = {instr[31:12], 12'b0};
         end
         default: legal = 1'b0;
      endcase
   end

   // Unused source fields are zeroed, so they also read x0 and never match a hazard.
   assign rs1_d = use_rs1 ? instr[19:15] : 5'd0;
   assign rs2_d = use_rs2 ? instr[24:20] : 5'd0;
   assign rd_d  = legal   ? instr[11:7]  : 5'd0;

   regfile_2r1w u_regfile (
      .clk   (clk),
      .rst_n (rst_n),
      .ra1   (rs1_d),
      .ra2   (rs2_d),
      .rd1   (rd1),
      .rd2   (rd2),
      .we    (bus.RegWrite_WB),
      .wa    (bus.Rd_WB),
      .wd    (bus.WriteData_WB)
   );

   assign load_use = ctrl_q.mem_read && (rd_q != 5'd0) &&
                     ((rs1_d == rd_q) || (rs2_d == rd_q));
   assign bubble   = bus.PCSrc_EX || squash_q || load_use;

   // Flush and squash already discard this instruction, so stalling would only lose a fetch.
   assign bus.PCWrite    = !(load_use && !bus.PCSrc_EX && !squash_q);
   assign bus.Write_IFID = bus.PCWrite;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         squash_q   <= 1'b0;
         ctrl_q     <= CTRL_BUBBLE;
         pc_q       <= '0;
         rd1_q      <= '0;
         rd2_q      <= '0;
         imm_q      <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         funct3_q   <= '0;
         funct7b5_q <= 1'b0;
      end else begin
         squash_q <= bus.PCSrc_EX;
         if (bubble) begin
            ctrl_q     <= CTRL_BUBBLE;
            pc_q       <= '0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            funct3_q   <= '0;
            funct7b5_q <= 1'b0;
         end else begin
            ctrl_q     <= ctrl_d;
            pc_q       <= bus.PC_IFID;
            rd1_q      <= rd1;
            rd2_q      <= rd2;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            funct3_q   <= instr[14:12];
            funct7b5_q <= instr[30];
         end
      end
   end

   assign bus.PC_IDEX       = pc_q;
   assign bus.RD1_IDEX      = rd1_q;
   assign bus.RD2_IDEX      = rd2_q;
   assign bus.Imm_IDEX      = imm_q;
   assign bus.Rs1_IDEX      = rs1_q;
   assign bus.Rs2_IDEX      = rs2_q;
   assign bus.Rd_IDEX       = rd_q;
   assign bus.Funct3_IDEX   = funct3_q;
   assign bus.Funct7b5_IDEX = funct7b5_q;
   assign bus.RegWrite_IDEX = ctrl_q.reg_write;
   assign bus.MemRead_IDEX  = ctrl_q.mem_read;
   assign bus.MemWrite_IDEX = ctrl_q.mem_write;
   assign bus.MemToReg_IDEX = ctrl_q.mem_to_reg;
   assign bus.ALUSrc_IDEX   = ctrl_q.alu_src;
   assign bus.ALUSrcA_IDEX  = ctrl_q.alu_src_a;
   assign bus.Branch_IDEX   = ctrl_q.branch;
   assign bus.Jump_IDEX     = ctrl_q.jump;
   assign bus.ALUOp_IDEX    = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_hazard_stage.sv
// Directed bench for id_hazard_stage; expectations are hand-decoded RV32I encodings.
module tb_id_hazard_stage;
   logic clk;
   logic rst_n;
   logic [31:0] pc;
   logic [31:0] exp_pc;
   int n_pass;
   int n_total;

   id_hazard_stage_if bus ();

   id_hazard_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [31:0] NOP       = 32'h0000_0013;
   localparam logic [31:0] ADDI_X1_5 = 32'h0050_0093;
   localparam logic [31:0] LW_X5     = 32'h0000_A283;
   localparam logic [31:0] ADD_X6    = 32'h0022_8333;
   localparam logic [31:0] LUI_X5    = 32'h0000_12B7;
   localparam logic [31:0] ADDI_X3   = 32'h0010_0193;
   localparam logic [31:0] ADDI_X4   = 32'h0020_0213;
   localparam logic [31:0] ADDI_X8   = 32'h0030_0413;
   localparam logic [31:0] BEQ       = 32'hFE00_0EE3;
   localparam logic [31:0] JAL       = 32'h0080_006F;
   localparam logic [31:0] SW        = 32'hFE11_2E23;
   localparam logic [31:0] ADDI_X9_7 = 32'h0003_8493;
   localparam logic [31:0] ADDI_X9_0 = 32'h0000_0493;
   localparam logic [31:0] ILLEGAL   = 32'h0000_007F;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] ins, input logic pcsrc);
      bus.Instruc_IFID = ins;
      bus.PC_IFID      = pc;
      bus.PCSrc_EX     = pcsrc;
      pc               = pc + 32'd4;
      #1;
   endtask

   task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
      bus.RegWrite_WB  = en;
      bus.Rd_WB        = r;
      bus.WriteData_WB = d;
   endtask

   function automatic logic [31:0] ctrl_obs();
      return {22'd0, bus.RegWrite_IDEX, bus.MemRead_IDEX, bus.MemWrite_IDEX,
              bus.MemToReg_IDEX, bus.ALUSrc_IDEX, bus.ALUSrcA_IDEX,
              bus.Branch_IDEX, bus.Jump_IDEX, bus.ALUOp_IDEX};
   endfunction

   initial begin
      n_pass = 0;
      n_total = 0;
      pc = 32'h0000_0100;
      rst_n = 1'b0;
      bus.Instruc_IFID = NOP;
      bus.PC_IFID = '0;
      bus.PCSrc_EX = 1'b0;
      wb(1'b0, 5'd0, 32'd0);
      #2;
      chk("rst_pcwrite", {31'd0, bus.PCWrite}, 32'd1);
      chk("rst_write_ifid", {31'd0, bus.Write_IFID}, 32'd1);
      chk("rst_ctrl", ctrl_obs(), 32'd0);
      chk("rst_rd", {27'd0, bus.Rd_IDEX}, 32'd0);
      tick;
      tick;
      rst_n = 1'b1;

      // Preload x1=100, x2=7
      wb(1'b1, 5'd1, 32'd100);
      issue(NOP, 1'b0);
      tick;
      wb(1'b1, 5'd2, 32'd7);
      tick;
      wb(1'b0, 5'd0, 32'd0);

      exp_pc = pc;
      issue(ADDI_X1_5, 1'b0);
      tick;
      chk("addi_imm", bus.Imm_IDEX, 32'd5);
      chk("addi_rd", {27'd0, bus.Rd_IDEX}, 32'd1);
      chk("addi_ctrl", ctrl_obs(), 32'b10_0010_0011);
      chk("addi_pc", bus.PC_IDEX, exp_pc);
      chk("addi_rd1", bus.RD1_IDEX, 32'd0);

      // Load-use stall
      issue(LW_X5, 1'b0);
      tick;
      chk("lw_ctrl", ctrl_obs(), 32'b11_0110_0000);
      chk("lw_rd1", bus.RD1_IDEX, 32'd100);
      issue(ADD_X6, 1'b0);
      chk("lu_pcwrite", {31'd0, bus.PCWrite}, 32'd0);
      chk("lu_write_ifid", {31'd0, bus.Write_IFID}, 32'd0);
      tick;
      chk("lu_bubble_ctrl", ctrl_obs(), 32'd0);
      chk("lu_bubble_rd", {27'd0, bus.Rd_IDEX}, 32'd0);
      chk("lu_release", {31'd0, bus.PCWrite}, 32'd1);
      tick;
      chk("add_rs1", {27'd0, bus.Rs1_IDEX}, 32'd5);
      chk("add_rs2", {27'd0, bus.Rs2_IDEX}, 32'd2);
      chk("add_rd", {27'd0, bus.Rd_IDEX}, 32'd6);
      chk("add_ctrl", ctrl_obs(), 32'b10_0000_0010);
      chk("add_rd2", bus.RD2_IDEX, 32'd7);

      // lw x5 then lui x5: lui uses no source register
      issue(LW_X5, 1'b0);
      tick;
      issue(LUI_X5, 1'b0);
      chk("lui_nostall", {31'd0, bus.PCWrite}, 32'd1);
      tick;
      chk("lui_rd", {27'd0, bus.Rd_IDEX}, 32'd5);
      chk("lui_rs1", {27'd0, bus.Rs1_IDEX}, 32'd0);
      chk("lui_imm", bus.Imm_IDEX, 32'h0000_1000);
      chk("lui_ctrl", ctrl_obs(), 32'b10_0010_0000);

      // Taken branch: two bubbles then the target
      issue(ADDI_X3, 1'b1);
      tick;
      chk("flush_bubble", ctrl_obs(), 32'd0);
      issue(ADDI_X4, 1'b0);
      tick;
      chk("squash_bubble", ctrl_obs(), 32'd0);
      chk("squash_rd", {27'd0, bus.Rd_IDEX}, 32'd0);
      issue(ADDI_X8, 1'b0);
      tick;
      chk("target_rd", {27'd0, bus.Rd_IDEX}, 32'd8);
      chk("target_imm", bus.Imm_IDEX, 32'd3);

      // Flush coinciding with load-use
      issue(LW_X5, 1'b0);
      tick;
      issue(ADD_X6, 1'b1);
      chk("flush_lu_pcwrite", {31'd0, bus.PCWrite}, 32'd1);
      chk("flush_lu_write_ifid", {31'd0, bus.Write_IFID}, 32'd1);
      tick;
      chk("flush_lu_bubble", ctrl_obs(), 32'd0);
      issue(ADDI_X4, 1'b0);
      tick;
      chk("flush_lu_squash", {27'd0, bus.Rd_IDEX}, 32'd0);

      // Immediate forms
      issue(BEQ, 1'b0);
      tick;
      chk("beq_imm", bus.Imm_IDEX, 32'hFFFF_FFFC);
      chk("beq_ctrl", ctrl_obs(), 32'b00_0000_1001);
      issue(JAL, 1'b0);
      tick;
      chk("jal_imm", bus.Imm_IDEX, 32'd8);
      chk("jal_ctrl", ctrl_obs(), 32'b10_0011_0100);
      chk("jal_rs1", {27'd0, bus.Rs1_IDEX}, 32'd0);
      issue(SW, 1'b0);
      tick;
      chk("sw_imm", bus.Imm_IDEX, 32'hFFFF_FFFC);
      chk("sw_ctrl", ctrl_obs(), 32'b00_1010_0000);
      chk("sw_rs", {22'd0, bus.Rs1_IDEX, bus.Rs2_IDEX}, {22'd0, 5'd2, 5'd1});

      // Register file
      wb(1'b1, 5'd7, 32'hDEAD_BEEF);
      issue(NOP, 1'b0);
      tick;
      wb(1'b0, 5'd0, 32'd0);
      issue(ADDI_X9_7, 1'b0);
      tick;
      chk("rf_x7", bus.RD1_IDEX, 32'hDEAD_BEEF);
      wb(1'b1, 5'd0, 32'h1234_5678);
      issue(NOP, 1'b0);
      tick;
      wb(1'b0, 5'd0, 32'd0);
      issue(ADDI_X9_0, 1'b0);
      tick;
      chk("rf_x0", bus.RD1_IDEX, 32'd0);
      wb(1'b1, 5'd7, 32'hCAFE_F00D);
      issue(ADDI_X9_7, 1'b0);
      tick;
      wb(1'b0, 5'd0, 32'd0);
`ifdef IDHZ_WB_BYPASS_EN
      chk("rf_same_cycle", bus.RD1_IDEX, 32'hCAFE_F00D);
`else
      chk("rf_same_cycle", bus.RD1_IDEX, 32'hDEAD_BEEF);
`endif
      issue(ADDI_X9_7, 1'b0);
      tick;
      chk("rf_after_write", bus.RD1_IDEX, 32'hCAFE_F00D);

      // Illegal opcode decodes to a bubble
      issue(ILLEGAL, 1'b0);
      tick;
      chk("illegal_ctrl", ctrl_obs(), 32'd0);

      // Reset during a stall
      issue(LW_X5, 1'b0);
      tick;
      issue(ADD_X6, 1'b0);
      chk("pre_rst_stall", {31'd0, bus.PCWrite}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("rst_stall_pcwrite", {31'd0, bus.PCWrite}, 32'd1);
      chk("rst_stall_ctrl", ctrl_obs(), 32'd0);
      rst_n = 1'b1;
      #1;

      // Reset during a squash leaves no residual squash
      issue(ADDI_X3, 1'b1);
      tick;
      issue(ADDI_X8, 1'b0);
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      #1;
      tick;
      chk("rst_squash_rd", {27'd0, bus.Rd_IDEX}, 32'd8);
      chk("rst_squash_ctrl", ctrl_obs(), 32'b10_0010_0011);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
